// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path.
// Entry layout is shared by the load buffer and the arbiter.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_PASS
  } wb_src_e;

  function automatic logic is_zero(
    input logic [REG_ADDR_W-1:0] rd
  );
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer holding load results that lost arbitration.
// Pointers wrap modulo DEPTH; count is fully registered.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by ALU and load results,
// with a load buffer and a pending-load scoreboard.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  load_issue,
  input  logic [REG_ADDR_W-1:0] load_issue_rd,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd_q,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] waddress,
  output logic [XLEN-1:0]       wdata
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         head;
  wb_entry_t         in_load;
  wb_entry_t         sel;
  wb_src_e           src;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              accept;
  logic              alu_win;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              out_load;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  assign load_ready = !full;
  assign accept     = load_valid && load_ready;
  assign alu_win    = alu_valid && !is_zero(alu_rd);

  assign in_load.rd   = load_rd;
  assign in_load.data = DATA_W'(load_data);

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      alu_win:                     src = SRC_ALU;
      !alu_win && !empty:          src = SRC_FIFO;
      !alu_win && empty && accept: src = SRC_PASS;
      default:                     src = SRC_NONE;
    endcase
  end

  always_comb begin
    sel = '0;
    unique case (src)
      SRC_ALU: begin
        sel.rd   = alu_rd;
        sel.data = DATA_W'(alu_data);
      end
      SRC_FIFO: sel = head;
      SRC_PASS: sel = in_load;
      default:  sel = '0;
    endcase
  end

  // A pass-through load is consumed directly and never enters the buffer.
  assign push  = accept && (src != SRC_PASS);
  assign pop   = (src == SRC_FIFO);
  assign wr_en = (src != SRC_NONE) && !is_zero(sel.rd);

  wb_load_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_load),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite <= 1'b0;
      waddress <= '0;
      wdata    <= '0;
      out_load <= 1'b0;
    end else begin
      regWrite <= wr_en;
      out_load <= wr_en && (src != SRC_ALU);
      if (wr_en) begin
        waddress <= sel.rd;
        wdata    <= XLEN'(sel.data);
      end
    end
  end

  // Clear lands with the regfile commit; a same-cycle reissue wins.
  always_comb begin
    busy_nxt = busy;
    if (regWrite && out_load)
      busy_nxt[waddress] = 1'b0;
    if (load_issue && !is_zero(load_issue_rd))
      busy_nxt[load_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[rd_q];

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: pass-through, priority,
// buffer fill/wrap, x0 handling, busy collision and mid-stream reset.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        load_issue = 1'b0;
  logic [4:0]  load_issue_rd = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [4:0]  load_rd = '0;
  logic [31:0] load_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd_q = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        regWrite;
  logic [4:0]  waddress;
  logic [31:0] wdata;

  int n_assert = 0;
  int n_fail   = 0;

  writeback_arbiter #(.XLEN(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .load_issue    (load_issue),
    .load_issue_rd (load_issue_rd),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd_q          (rd_q),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_busy       (rd_busy),
    .regWrite      (regWrite),
    .waddress      (waddress),
    .wdata         (wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid  = 1'b0;
    load_issue = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [4:0]  exp_wa [7] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd8, 5'd9, 5'd10};
  logic [31:0] exp_wd [7] = '{32'h100, 32'h101, 32'h102, 32'h103,
                              32'h80, 32'h90, 32'hA0};
  logic        lv     [7] = '{1, 1, 1, 1, 1, 1, 0};
  logic [4:0]  lrd    [7] = '{5'd8, 5'd9, 5'd10, 5'd10, 5'd10, 5'd10, 5'd0};
  logic [31:0] ldat   [7] = '{32'h80, 32'h90, 32'hA0, 32'hA0,
                              32'hA0, 32'hA0, 32'h0};
  logic        exp_rdy[7] = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_waddress", 32'(waddress), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);

    // Load pass-through with busy tracking
    load_issue = 1'b1; load_issue_rd = 5'd7;
    tick();
    idle();
    rs1 = 5'd7;
    #1 chk("pt_busy_set", 32'(rs1_busy), 32'd1);
    load_valid = 1'b1; load_rd = 5'd7; load_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("pt_regWrite", 32'(regWrite), 32'd1);
    chk("pt_waddress", 32'(waddress), 32'd7);
    chk("pt_wdata", wdata, 32'hDEADBEEF);
    chk("pt_busy_hold", 32'(rs1_busy), 32'd1);
    tick();
    chk("pt_busy_clr", 32'(rs1_busy), 32'd0);
    chk("pt_idle", 32'(regWrite), 32'd0);
    chk("pt_addr_hold", 32'(waddress), 32'd7);

    // ALU priority over a concurrent load
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    load_valid = 1'b1; load_rd = 5'd4; load_data = 32'h22;
    tick();
    idle();
    chk("pri_alu_addr", 32'(waddress), 32'd3);
    chk("pri_alu_data", wdata, 32'h11);
    tick();
    chk("pri_ld_we", 32'(regWrite), 32'd1);
    chk("pri_ld_addr", 32'(waddress), 32'd4);
    chk("pri_ld_data", wdata, 32'h22);
    tick();
    chk("pri_idle", 32'(regWrite), 32'd0);

    // ALU burst fills the buffer; pointers wrap
    for (int i = 0; i < 7; i++) begin
      alu_valid  = (i < 4);
      alu_rd     = 5'(20 + i);
      alu_data   = 32'h100 + 32'(i);
      load_valid = lv[i];
      load_rd    = lrd[i];
      load_data  = ldat[i];
      #1 chk($sformatf("full_ready%0d", i), 32'(load_ready),
             32'(exp_rdy[i]));
      tick();
      chk($sformatf("full_we%0d", i), 32'(regWrite), 32'd1);
      chk($sformatf("full_addr%0d", i), 32'(waddress), 32'(exp_wa[i]));
      chk($sformatf("full_data%0d", i), wdata, exp_wd[i]);
    end
    idle();
    tick();
    chk("full_drain_we", 32'(regWrite), 32'd0);
    chk("full_drain_ready", 32'(load_ready), 32'd1);

    // x0 handling
    load_issue = 1'b1; load_issue_rd = 5'd0;
    tick();
    idle();
    rs1 = 5'd0;
    #1 chk("x0_busy", 32'(rs1_busy), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5;
    load_valid = 1'b1; load_rd = 5'd0; load_data = 32'h6;
    tick();
    idle();
    chk("x0_we", 32'(regWrite), 32'd0);
    chk("x0_ready", 32'(load_ready), 32'd1);
    chk("x0_addr_hold", 32'(waddress), 32'd10);
    tick();
    chk("x0_we2", 32'(regWrite), 32'd0);
    chk("x0_ready2", 32'(load_ready), 32'd1);

    // Set/clear collision on x12
    load_issue = 1'b1; load_issue_rd = 5'd12;
    tick();
    idle();
    load_valid = 1'b1; load_rd = 5'd12; load_data = 32'hC;
    tick();
    idle();
    chk("col_we", 32'(regWrite), 32'd1);
    chk("col_addr", 32'(waddress), 32'd12);
    load_issue = 1'b1; load_issue_rd = 5'd12;
    tick();
    idle();
    rd_q = 5'd12; rs2 = 5'd12;
    #1 chk("col_rd_busy", 32'(rd_busy), 32'd1);
    chk("col_rs2_busy", 32'(rs2_busy), 32'd1);
    load_valid = 1'b1; load_rd = 5'd12; load_data = 32'hD;
    tick();
    idle();
    tick();
    chk("col_retire", 32'(rd_busy), 32'd0);

    // Reset with two loads buffered and x5/x6 busy
    load_issue = 1'b1; load_issue_rd = 5'd5;
    tick();
    load_issue_rd = 5'd6;
    tick();
    load_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    load_valid = 1'b1; load_rd = 5'd5; load_data = 32'h55;
    tick();
    alu_rd = 5'd2; alu_data = 32'h2;
    load_rd = 5'd6; load_data = 32'h66;
    tick();
    idle();
    rs1 = 5'd5; rs2 = 5'd6;
    #1 chk("mid_ready_full", 32'(load_ready), 32'd0);
    chk("mid_busy5", 32'(rs1_busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_async_we", 32'(regWrite), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("mid_ready", 32'(load_ready), 32'd1);
    chk("mid_busy5_clr", 32'(rs1_busy), 32'd0);
    chk("mid_busy6_clr", 32'(rs2_busy), 32'd0);
    tick();
    chk("mid_stale1", 32'(regWrite), 32'd0);
    tick();
    chk("mid_stale2", 32'(regWrite), 32'd0);
    chk("mid_addr", 32'(waddress), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
